// File: rtl/user_mgr_arbiter_if.sv
// Signal bundle between the user-domain OBI managers, the arbiter and the
// shared downstream OBI manager port. The arbiter connects through the
// slave modport; the surrounding environment connects through master.
interface user_mgr_arbiter_if #(
  parameter int unsigned NumMgr    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned BeWidth = DataWidth / 8;

  // Upstream (per-requester) side
  logic [NumMgr-1:0]           in_req_i;
  logic [NumMgr*AddrWidth-1:0] in_addr_i;
  logic [NumMgr-1:0]           in_we_i;
  logic [NumMgr*BeWidth-1:0]   in_be_i;
  logic [NumMgr*DataWidth-1:0] in_wdata_i;
  logic [NumMgr-1:0]           in_gnt_o;
  logic [NumMgr-1:0]           in_rvalid_o;
  logic [DataWidth-1:0]        in_rdata_o;
  logic                        in_err_o;

  // Downstream (shared) side
  logic                        out_req_o;
  logic [AddrWidth-1:0]        out_addr_o;
  logic                        out_we_o;
  logic [BeWidth-1:0]          out_be_o;
  logic [DataWidth-1:0]        out_wdata_o;
  logic                        out_gnt_i;
  logic                        out_rvalid_i;
  logic [DataWidth-1:0]        out_rdata_i;
  logic                        out_err_i;

  // Response arriving with nothing outstanding
  logic                        unexp_rsp_o;

  modport slave (
    input  in_req_i, in_addr_i, in_we_i, in_be_i, in_wdata_i,
    input  out_gnt_i, out_rvalid_i, out_rdata_i, out_err_i,
    output in_gnt_o, in_rvalid_o, in_rdata_o, in_err_o,
    output out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o,
    output unexp_rsp_o
  );

  modport master (
    output in_req_i, in_addr_i, in_we_i, in_be_i, in_wdata_i,
    output out_gnt_i, out_rvalid_i, out_rdata_i, out_err_i,
    input  in_gnt_o, in_rvalid_o, in_rdata_o, in_err_o,
    input  out_req_o, out_addr_o, out_we_o, out_be_o, out_wdata_o,
    input  unexp_rsp_o
  );
endinterface

// File: rtl/user_mgr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port between NumMgr user-domain
// managers. A request left waiting for grant is locked so addr/data stay
// stable; an in-order ID FIFO routes each response back to its issuer.
module user_mgr_arbiter #(
  parameter int unsigned NumMgr    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  user_mgr_arbiter_if.slave bus
);
  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned IdxWidth = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  arb_state_e          state_q, state_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [IdxWidth-1:0] fifo_mem_q [MaxTrans];

  logic [IdxWidth-1:0] sel;
  logic                any_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  logic [NumMgr-1:0]    in_gnt;
  logic [NumMgr-1:0]    in_rvalid;
  logic [DataWidth-1:0] in_rdata;
  logic                 in_err;
  logic                 out_req;
  logic [AddrWidth-1:0] out_addr;
  logic                 out_we;
  logic [BeWidth-1:0]   out_be;
  logic [DataWidth-1:0] out_wdata;
  logic                 unexp_rsp;

  // Pick the granted requester: the locked one, else first requester from ptr
  always_comb begin
    int unsigned         cand_int;
    logic [IdxWidth-1:0] cand;
    logic                found;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    sel      = '0;
    cand_int = 0;
    cand     = '0;
    found    = 1'b0;
    if (state_q == ARB_LOCKED) begin
      sel = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NumMgr; k++) begin
        cand_int = 32'(ptr_q) + k;
        if (cand_int >= NumMgr) cand_int = cand_int - NumMgr;
        cand = cand_int[IdxWidth-1:0];
        if (!found && bus.in_req_i[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Downstream request mux, zero-latency grant and response routing
  always_comb begin
    any_req    = |bus.in_req_i;
    fifo_full  = (cnt_q == CntWidth'(MaxTrans));
    fifo_empty = (cnt_q == '0);

    out_req   = any_req && !fifo_full && !rst_i;
    out_addr  = '0;
    out_we    = 1'b0;
    out_be    = '0;
    out_wdata = '0;
    if (any_req && !rst_i) begin
      out_addr  = bus.in_addr_i[32'(sel)*AddrWidth +: AddrWidth];
      out_we    = bus.in_we_i[sel];
      out_be    = bus.in_be_i[32'(sel)*BeWidth +: BeWidth];
      out_wdata = bus.in_wdata_i[32'(sel)*DataWidth +: DataWidth];
    end

    push   = out_req && bus.out_gnt_i;
    in_gnt = '0;
    if (push) in_gnt[sel] = 1'b1;

    pop       = bus.out_rvalid_i && !fifo_empty && !rst_i;
    unexp_rsp = bus.out_rvalid_i && fifo_empty && !rst_i;
    in_rvalid = '0;
    in_rdata  = '0;
    in_err    = 1'b0;
    if (pop) begin
      in_rvalid[fifo_mem_q[rd_ptr_q]] = 1'b1;
      in_rdata = bus.out_rdata_i;
      in_err   = bus.out_err_i;
    end
  end

  // Next-state for lock, round-robin pointer and FIFO bookkeeping
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      state_d  = ARB_FREE;
      ptr_d    = (32'(sel) == NumMgr - 1) ? '0 : sel + IdxWidth'(1);
      wr_ptr_d = (wr_ptr_q == PtrWidth'(MaxTrans - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
    end else if (out_req) begin
      state_d    = ARB_LOCKED;
      lock_idx_d = sel;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrWidth'(MaxTrans - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    cnt_d = cnt_q + CntWidth'(push) - CntWidth'(pop);
  end

  // Control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_FREE;
      lock_idx_q <= '0;
      ptr_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // ID FIFO storage
  // NOTE: storage is not reset; an entry is only read after being written, as cnt_q tracks.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= sel;
  end

  assign bus.in_gnt_o    = in_gnt;
  assign bus.in_rvalid_o = in_rvalid;
  assign bus.in_rdata_o  = in_rdata;
  assign bus.in_err_o    = in_err;
  assign bus.out_req_o   = out_req;
  assign bus.out_addr_o  = out_addr;
  assign bus.out_we_o    = out_we;
  assign bus.out_be_o    = out_be;
  assign bus.out_wdata_o = out_wdata;
  assign bus.unexp_rsp_o = unexp_rsp;

endmodule

// File: tb/tb_user_mgr_arbiter.sv
// Randomized bench for user_mgr_arbiter. A driver plays the requesters and
// the downstream memory, predicts grants/downstream fields from the
// round-robin rules and queues expected responses; a monitor pops the queue
// and compares on the opposite clock edge.
module tb_user_mgr_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  user_mgr_arbiter_if #(.NumMgr(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

  user_mgr_arbiter #(
    .NumMgr(N), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(MT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [N-1:0]  vec;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  int checks = 0;
  int errors = 0;

  // Requester state: a pending transaction is held until granted
  bit            act     [N];
  logic [AW-1:0] r_addr  [N];
  logic          r_we    [N];
  logic [BW-1:0] r_be    [N];
  logic [DW-1:0] r_wdata [N];

  // Reference model: rotating priority, lock, outstanding issuer queue
  int   ptr      = 0;
  bit   locked   = 0;
  int   lock_idx = 0;
  int   outst[$];
  rsp_t sb[$];

  bit e_req = 0;
  bit e_hs  = 0;
  bit e_pop = 0;
  int e_sel = 0;

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act_v, exp_v);
    end
  endtask

  task automatic drive_inputs(input int pct0, input int pct1, input int gnt_pct, input int rv_pct);
    for (int i = 0; i < N; i++) begin
      if (!act[i] && $urandom_range(0, 99) < ((i == 0) ? pct0 : pct1)) begin
        act[i]     = 1'b1;
        r_addr[i]  = {$urandom_range(0, 255), 2'b00} + 32'h1000_0000 * (i + 1);
        r_we[i]    = 1'($urandom_range(0, 1));
        r_be[i]    = 4'($urandom_range(1, 15));
        r_wdata[i] = $urandom;
      end
      bus.in_req_i[i]                = act[i];
      bus.in_addr_i[i*AW +: AW]      = r_addr[i];
      bus.in_we_i[i]                 = r_we[i];
      bus.in_be_i[i*BW +: BW]        = r_be[i];
      bus.in_wdata_i[i*DW +: DW]     = r_wdata[i];
    end
    bus.out_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
    bus.out_rvalid_i = ($urandom_range(0, 99) < rv_pct);
    bus.out_rdata_i  = $urandom;
    bus.out_err_i    = ($urandom_range(0, 7) == 0);
  endtask

  // Predict this cycle's DUT outputs from the arbitration rules and compare
  task automatic evaluate();
    bit            any;
    int            sel;
    logic [N-1:0]  g;
    logic [N-1:0]  one;
    bit            rv;
    any = 1'b0;
    for (int i = 0; i < N; i++) if (act[i]) any = 1'b1;
    sel = 0;
    if (locked) sel = lock_idx;
    else for (int k = N - 1; k >= 0; k--) if (act[(ptr + k) % N]) sel = (ptr + k) % N;
    e_sel = sel;
    e_req = any && (outst.size() < MT);
    e_hs  = e_req && bus.out_gnt_i;
    rv    = bus.out_rvalid_i;
    e_pop = rv && (outst.size() > 0);
    g = '0;
    if (e_hs) g[sel] = 1'b1;
    check("out_req", 64'(bus.out_req_o), 64'(e_req));
    check("in_gnt", 64'(bus.in_gnt_o), 64'(g));
    check("out_addr", 64'(bus.out_addr_o), any ? 64'(r_addr[sel]) : 64'd0);
    check("out_we", 64'(bus.out_we_o), any ? 64'(r_we[sel]) : 64'd0);
    check("out_be", 64'(bus.out_be_o), any ? 64'(r_be[sel]) : 64'd0);
    check("out_wdata", 64'(bus.out_wdata_o), any ? 64'(r_wdata[sel]) : 64'd0);
    check("unexp_rsp", 64'(bus.unexp_rsp_o), 64'(rv && outst.size() == 0));
    if (e_pop) begin
      one = 1;
      sb.push_back('{vec: one << outst[0], rdata: bus.out_rdata_i, err: bus.out_err_i});
    end
  endtask

  // Apply the effects of the cycle that just ended at the clock edge
  task automatic commit();
    if (e_pop) void'(outst.pop_front());
    if (e_hs) begin
      outst.push_back(e_sel);
      ptr         = (e_sel + 1) % N;
      locked      = 1'b0;
      act[e_sel]  = 1'b0;
    end else if (e_req) begin
      locked   = 1'b1;
      lock_idx = e_sel;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_req"}, 64'(bus.out_req_o), 64'd0);
    check({tag, "_in_gnt"}, 64'(bus.in_gnt_o), 64'd0);
    check({tag, "_in_rvalid"}, 64'(bus.in_rvalid_o), 64'd0);
    check({tag, "_unexp"}, 64'(bus.unexp_rsp_o), 64'd0);
    check({tag, "_out_fields"}, 64'(|{bus.out_addr_o, bus.out_we_o, bus.out_be_o, bus.out_wdata_o,
                                      bus.in_rdata_o, bus.in_err_o}), 64'd0);
  endtask

  // Assert reset away from the edge, check outputs idle, release and resume
  task automatic reset_phase(input string tag);
    rst = 1'b1;
    #1 check_zero(tag);
    outst.delete();
    ptr      = 0;
    locked   = 1'b0;
    lock_idx = 0;
    e_req    = 1'b0;
    e_hs     = 1'b0;
    e_pop    = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 check_zero(tag);
    end
    rst = 1'b0;
    #1 evaluate();
  endtask

  // Monitor: every negedge, a queued response must be presented, else none
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        check("rsp_vec", 64'(bus.in_rvalid_o), 64'(r.vec));
        check("rsp_rdata", 64'(bus.in_rdata_o), 64'(r.rdata));
        check("rsp_err", 64'(bus.in_err_o), 64'(r.err));
      end else begin
        check("no_rsp", 64'(bus.in_rvalid_o), 64'd0);
      end
    end
  end

  // Driver: stimulus phases with model-predicted outputs
  initial begin
    bit did_mid_reset = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    drive_inputs(100, 100, 100, 100);
    reset_phase("reset");

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1 commit();
      if (cyc < 200)       drive_inputs(60, 0, 70, 40);   // requester 0 alone
      else if (cyc < 400)  drive_inputs(100, 100, 100, 50); // both held, grant every cycle
      else if (cyc < 1500) drive_inputs(50, 50, 60, 20);  // FIFO tends to fill
      else                 drive_inputs(50, 50, 40, 60);  // long lock stalls
      if (!did_mid_reset && cyc > 600 && (outst.size() == MT || cyc == 1400)) begin
        did_mid_reset    = 1'b1;
        bus.out_rvalid_i = 1'b1;
        reset_phase("midrst");
      end else begin
        #1 evaluate();
      end
    end

    @(posedge clk);
    #1 commit();
    for (int i = 0; i < N; i++) bus.in_req_i[i] = 1'b0;
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    bus.out_rvalid_i = 1'b0;
    bus.out_gnt_i    = 1'b0;
    #1 evaluate();
    @(negedge clk);
    #1 check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
